diferencial_transmisor: RTL and testbench
=========================================

# diferencial_transmisor

Serial-to-differential line transmitter for the PHY lane, the transmit-side counterpart of the differential receiver. The receiver decodes a 1 wherever the line level changes. This block therefore NRZI-encodes a serial bit stream: the line toggles for a 1 and holds for a 0. It drives the D+/D- pair and manages electrical idle, including a wake pattern on exit from idle and auto-entry to idle on inactivity. It sits between the serializer (upstream, valid/ready) and the lane pins.

## Interface
- WAKE_CYCLES, default 4: number of cycles of alternating wake pattern driven before data is accepted. Must be ≥1.
- IDLE_TIMEOUT, default 16: consecutive ACTIVO cycles with no valid bit before auto-entry to electrical idle. 0 disables the timeout.

- clk  in  1  single clock for the block.
- rst  in  1  reset, synchronous, active-high.
- enb  in  1  clock enable. While 0, all registers hold and listo=0.
- entrada  in  1  serial data bit.
- entrada_valid  in  1  entrada holds a bit to send.
- listo  out  1  ready. A bit is accepted on an edge where entrada_valid & listo. Combinational: (estado==ACTIVO) & enb & !TxElecIdle.
- TxElecIdle  in  1  request for electrical idle (level-sensitive).
- salidaP  out  1  D+, registered.
- salidaN  out  1  D-, registered.
- enIdle  out  1  status, registered; 1 while in ELEC_IDLE.

## Operation
- Reset values: estado=ELEC_IDLE, nivel=0, salidaP=0, salidaN=0, enIdle=1, wake and timeout counters 0. listo=0 follows from estado.
- ELEC_IDLE:
  - Outputs: salidaP=salidaN=0 (common mode), enIdle=1.
  - Exit to WAKE on an edge with TxElecIdle=0 & entrada_valid=1. The pending bit is not consumed.
- WAKE:
  - nivel is 1 on the first WAKE cycle and toggles every cycle after that. The pattern is 1,0,1,0… for exactly WAKE_CYCLES cycles.
  - Then go to ACTIVO with nivel unchanged.
  - TxElecIdle=1 in WAKE aborts to ELEC_IDLE on the next edge.
- ACTIVO:
  - Outputs: salidaP=nivel, salidaN=~nivel.
  - Accepted bit=1: nivel toggles. Accepted bit=0: nivel holds.
  - No valid bit: nivel holds (line-equivalent to sending 0), and the timeout counter increments. Any accepted bit clears it.
  - Counter reaching IDLE_TIMEOUT (nonzero): ELEC_IDLE on the next edge.
  - TxElecIdle=1: listo drops in the same cycle, no bit is accepted, and estado becomes ELEC_IDLE on that edge.
- On entry to ELEC_IDLE: nivel resets to 0 and the counters clear.
- Priority: rst > enb=0 > TxElecIdle > timeout > data.

## Timing
- Data latency is 1 cycle. A bit accepted at edge k is reflected on salidaP/salidaN immediately after edge k.
- Idle exit: request sampled at edge k gives salidaP=1, salidaN=0, enIdle=0 after edge k. listo first rises WAKE_CYCLES cycles later.
- Idle entry: TxElecIdle sampled at edge k gives salidaP=salidaN=0 and enIdle=1 after edge k.
- salidaN is always ~salidaP outside ELEC_IDLE. Both are 0 inside it; no other combination is legal.
- Reset asserted mid-stream: on the next edge all outputs take their reset values, regardless of enb.
- enb=0 freezes the outputs and counters. Wake and timeout counting resume where they stopped.
- Timeout counter width: $clog2(IDLE_TIMEOUT+1). It saturates and does not wrap.

## Structure
- Shared package/include diferencial_pkg:
  - State encoding: ELEC_IDLE=2'b00, WAKE=2'b01, ACTIVO=2'b10; 2'b11 is illegal and recovers to ELEC_IDLE.
  - Default WAKE_CYCLES and IDLE_TIMEOUT constants, shared with the receiver bench.
- One sub-module, codificador_nrzi:
  - Holds the nivel register, with toggle/hold/force-zero controls and the salidaP/salidaN drive.
  - The FSM and counters live in the top.

## Test plan
- Reset, then TxElecIdle=1, entrada_valid=1 for 10 cycles → salidaP=salidaN=0, enIdle=1, listo=0 throughout.
- TxElecIdle=0, valid with bits 1,0,1,1,0 (WAKE_CYCLES=4) → after request edge salidaP=1,0,1,0; listo high on cycle 5; then salidaP=1,1,0,1,1. The receiver model recovers 1,0,1,1,0.
- In ACTIVO, valid=0 for IDLE_TIMEOUT=16 cycles → salidaP holds for 16 cycles, then both outputs 0 and enIdle=1 on the next edge.
- Assert TxElecIdle on the 2nd WAKE cycle with valid=1 → ELEC_IDLE on the next edge, and no bit is accepted.
- enb=0 for 3 cycles mid-stream with valid=1 → outputs frozen, listo=0, no bits consumed; the stream resumes intact.
- rst pulsed for 1 cycle during ACTIVO with nivel=1 → salidaP=0, salidaN=0, enIdle=1 on the next edge.

Source files
------------

// File: rtl/diferencial_pkg.sv
// Shared definitions for the differential lane transmitter and its receiver bench:
// state encoding, default timing constants and a counter-width helper.
package diferencial_pkg;

    typedef enum logic [1:0] {
        ELEC_IDLE = 2'b00,
        WAKE      = 2'b01,
        ACTIVO    = 2'b10,
        ILEGAL    = 2'b11
    } estado_t;

    localparam int WAKE_CYCLES_DEF  = 4;
    localparam int IDLE_TIMEOUT_DEF = 16;

    // Width able to hold 0..maxValor, never narrower than one bit.
    function automatic int anchoContador(input int maxValor);
        if (maxValor < 1) begin
            return 1;
        end else begin
            return $clog2(maxValor + 1);
        end
    endfunction

endpackage

// File: rtl/codificador_nrzi.sv
// NRZI line encoder: holds the line level and drives the D+/D- pair,
// or parks both pins low (common mode) when not driving.
module codificador_nrzi (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    input  logic toggle,
    input  logic clear,
    input  logic drive,
    output logic salidaP,
    output logic salidaN
);

    logic nivel_r;
    logic nivelNext_s;
    logic salidaP_r;
    logic salidaN_r;

    // Next line level: clear wins over toggle, otherwise hold.
    always_comb begin
        nivelNext_s = nivel_r;
        if (clear) begin
            nivelNext_s = 1'b0;
        end else if (toggle) begin
            nivelNext_s = ~nivel_r;
        end else begin
            nivelNext_s = nivel_r;
        end
    end

    // Level and pin registers; pins follow the level being loaded this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            nivel_r   <= 1'b0;
            salidaP_r <= 1'b0;
            salidaN_r <= 1'b0;
        end else if (enb) begin
            nivel_r   <= nivelNext_s;
            salidaP_r <= drive & nivelNext_s;
            salidaN_r <= drive & ~nivelNext_s;
        end
    end

    assign salidaP = salidaP_r;
    assign salidaN = salidaN_r;

endmodule

// File: rtl/diferencial_transmisor.sv
// Serial-to-differential transmitter: electrical-idle / wake / active FSM with
// wake and inactivity counters, driving an NRZI encoder.
module diferencial_transmisor
    import diferencial_pkg::*;
#(
    parameter int WAKE_CYCLES  = WAKE_CYCLES_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    input  logic entrada,
    input  logic entrada_valid,
    output logic listo,
    input  logic TxElecIdle,
    output logic salidaP,
    output logic salidaN,
    output logic enIdle
);

    localparam int WAKE_W = anchoContador(WAKE_CYCLES);
    localparam int TOUT_W = anchoContador(IDLE_TIMEOUT);
    localparam logic [WAKE_W-1:0] WAKE_ULTIMO = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LIMITE = TOUT_W'(IDLE_TIMEOUT);
    localparam bit TOUT_HABILITADO = (IDLE_TIMEOUT != 0);

    estado_t             estado_r;
    estado_t             estadoNext_s;
    logic [WAKE_W-1:0]   wakeCnt_r;
    logic [WAKE_W-1:0]   wakeCntNext_s;
    logic [TOUT_W-1:0]   toutCnt_r;
    logic [TOUT_W-1:0]   toutCntNext_s;
    logic                toggle_s;
    logic                clear_s;
    logic                drive_s;
    logic                enIdle_r;

    assign listo = (estado_r == ACTIVO) & enb & ~TxElecIdle;

    // Next state, counters and encoder controls; idle request beats timeout beats data.
    always_comb begin
        estadoNext_s  = estado_r;
        wakeCntNext_s = wakeCnt_r;
        toutCntNext_s = toutCnt_r;
        toggle_s      = 1'b0;
        clear_s       = 1'b0;
        case (estado_r)
            ELEC_IDLE: begin
                if (!TxElecIdle && entrada_valid) begin
                    // level is 0 here, so a toggle starts the wake pattern at 1
                    estadoNext_s  = WAKE;
                    wakeCntNext_s = '0;
                    toggle_s      = 1'b1;
                end else begin
                    estadoNext_s  = ELEC_IDLE;
                end
            end
            WAKE: begin
                if (TxElecIdle) begin
                    estadoNext_s  = ELEC_IDLE;
                    wakeCntNext_s = '0;
                    toutCntNext_s = '0;
                    clear_s       = 1'b1;
                end else if (wakeCnt_r == WAKE_ULTIMO) begin
                    estadoNext_s  = ACTIVO;
                    wakeCntNext_s = '0;
                    toutCntNext_s = '0;
                end else begin
                    wakeCntNext_s = wakeCnt_r + 1'b1;
                    toggle_s      = 1'b1;
                end
            end
            ACTIVO: begin
                if (TxElecIdle || (TOUT_HABILITADO && (toutCnt_r == TOUT_LIMITE))) begin
                    estadoNext_s  = ELEC_IDLE;
                    wakeCntNext_s = '0;
                    toutCntNext_s = '0;
                    clear_s       = 1'b1;
                end else if (entrada_valid) begin
                    toggle_s      = entrada;
                    toutCntNext_s = '0;
                end else if (toutCnt_r != '1) begin
                    toutCntNext_s = toutCnt_r + 1'b1;
                end else begin
                    toutCntNext_s = toutCnt_r;
                end
            end
            default: begin
                estadoNext_s  = ELEC_IDLE;
                wakeCntNext_s = '0;
                toutCntNext_s = '0;
                clear_s       = 1'b1;
            end
        endcase
        drive_s = (estadoNext_s != ELEC_IDLE);
    end

    // State, counters and idle status; everything freezes while enb is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r  <= ELEC_IDLE;
            wakeCnt_r <= '0;
            toutCnt_r <= '0;
            enIdle_r  <= 1'b1;
        end else if (enb) begin
            estado_r  <= estadoNext_s;
            wakeCnt_r <= wakeCntNext_s;
            toutCnt_r <= toutCntNext_s;
            enIdle_r  <= (estadoNext_s == ELEC_IDLE);
        end
    end

    assign enIdle = enIdle_r;

    codificador_nrzi uCodificador (
        .clk     (clk),
        .rst     (rst),
        .enb     (enb),
        .toggle  (toggle_s),
        .clear   (clear_s),
        .drive   (drive_s),
        .salidaP (salidaP),
        .salidaN (salidaN)
    );

endmodule

// File: tb/tb_diferencial_transmisor.sv
// Bench for diferencial_transmisor: directed scenarios plus random traffic checked
// against a cycle-level behavioural model and an NRZI receiver that decodes each accepted bit.
module tb_diferencial_transmisor;
    import diferencial_pkg::*;

    localparam int WC = WAKE_CYCLES_DEF;
    localparam int IT = IDLE_TIMEOUT_DEF;

    logic clk = 1'b0;
    logic rst, enb, entrada, entrada_valid, TxElecIdle;
    logic listo, salidaP, salidaN, enIdle;

    int nVectores = 0;
    int nFallos   = 0;

    // Behavioural model: modo 0=idle, 1=wake, 2=active
    int   mModo   = 0;
    int   mWake   = 0;
    int   mQuieto = 0;
    logic mNivel  = 1'b0;

    logic histP[$];

    always #5 clk = ~clk;

    diferencial_transmisor #(.WAKE_CYCLES(WC), .IDLE_TIMEOUT(IT)) dut (
        .clk           (clk),
        .rst           (rst),
        .enb           (enb),
        .entrada       (entrada),
        .entrada_valid (entrada_valid),
        .listo         (listo),
        .TxElecIdle    (TxElecIdle),
        .salidaP       (salidaP),
        .salidaN       (salidaN),
        .enIdle        (enIdle)
    );

    task automatic comparar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        nVectores++;
        if (obs !== esp) begin
            nFallos++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic modeloIdle();
        mModo   = 0;
        mNivel  = 1'b0;
        mWake   = 0;
        mQuieto = 0;
    endtask

    // One clock cycle: drive, check listo, clock, advance model, check pins and decoded bit.
    task automatic ciclo(input logic r, input logic e, input logic tx, input logic v, input logic d);
        logic prevP;
        logic aceptado;
        rst = r; enb = e; TxElecIdle = tx; entrada_valid = v; entrada = d;
        #1;
        comparar("listo", 32'(listo), 32'((mModo == 2) && e && !tx));
        prevP = salidaP;
        @(posedge clk);
        aceptado = 1'b0;
        if (r) begin
            modeloIdle();
        end else if (e) begin
            case (mModo)
                0: if (!tx && v) begin mModo = 1; mNivel = 1'b1; mWake = 1; end
                1: begin
                    if (tx) modeloIdle();
                    else if (mWake == WC) begin mModo = 2; mQuieto = 0; end
                    else begin mNivel = !mNivel; mWake++; end
                end
                default: begin
                    if (tx) modeloIdle();
                    else if (IT != 0 && mQuieto == IT) modeloIdle();
                    else if (v) begin
                        aceptado = 1'b1;
                        if (d) mNivel = !mNivel;
                        mQuieto = 0;
                    end else mQuieto++;
                end
            endcase
        end
        #1;
        comparar("salidaP", 32'(salidaP), 32'((mModo != 0) && mNivel));
        comparar("salidaN", 32'(salidaN), 32'((mModo != 0) && !mNivel));
        comparar("enIdle", 32'(enIdle), 32'(mModo == 0));
        if (aceptado) comparar("rx_bit", 32'(salidaP ^ prevP), 32'(d));
        histP.push_back(salidaP);
    endtask

    initial begin
        logic patron [5];
        logic pEsp [10];
        int   vUmbral;
        patron = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pEsp   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; enb = 1'b0; TxElecIdle = 1'b0; entrada_valid = 1'b0; entrada = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        comparar("reset_P", 32'(salidaP), 32'd0);
        comparar("reset_N", 32'(salidaN), 32'd0);
        comparar("reset_enIdle", 32'(enIdle), 32'd1);
        comparar("reset_listo", 32'(listo), 32'd0);

        // Idle requested while data waits: stays in idle
        repeat (10) ciclo(1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom_range(1, 0)));

        // Wake then bits 1,0,1,1,0
        histP.delete();
        ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (WC) ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        foreach (patron[i]) ciclo(1'b0, 1'b1, 1'b0, 1'b1, patron[i]);
        foreach (pEsp[i]) comparar("patron_P", 32'(histP[i]), 32'(pEsp[i]));

        // Inactivity timeout
        repeat (IT + 3) ciclo(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort on second wake cycle
        ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ciclo(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        comparar("abort_idle", 32'(enIdle), 32'd1);

        // Clock-enable freeze mid-stream
        ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (WC) ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom_range(1, 0)));
        repeat (3) ciclo(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(1, 0)));
        repeat (5) ciclo(1'b0, 1'b1, 1'b0, 1'b1, 1'($urandom_range(1, 0)));

        // Reset pulse while driving level 1
        ciclo(1'b0, 1'b1, 1'b0, 1'b1, !mNivel);
        comparar("pre_rst_P", 32'(salidaP), 32'd1);
        ciclo(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Random traffic with changing activity density
        vUmbral = 7;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) vUmbral = $urandom_range(10, 0);
            ciclo(1'($urandom_range(299, 0) == 0),
                  1'($urandom_range(9, 0) != 0),
                  1'($urandom_range(39, 0) == 0),
                  1'($urandom_range(9, 0) < vUmbral),
                  1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectores, nFallos);
        $finish;
    end

endmodule
